adder_rr_scheduler: RTL and testbench



---
 rtl/adder_rr_scheduler_pkg.sv | 17 +
 rtl/rr_arbiter_onehot.sv | 39 +++
 rtl/adder_rr_scheduler.sv | 112 +++++++++++
 tb/tb_adder_rr_scheduler.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_rr_scheduler_pkg.sv
// Shared types and constants for the round-robin adder scheduler.
// Output-stage FSM encoding, default widths and stats counter sizing.
package adder_rr_scheduler_pkg;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

    localparam int DEF_N    = 64;
    localparam int DEF_NREQ = 4;
    localparam int DEF_IDW  = 2;

    localparam int                 STAT_W   = 16;
    localparam logic [STAT_W-1:0]  STAT_SAT = '1;

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Round-robin arbiter: one-hot grant plus encoded index, searching upward from last_grant+1.
// Latency: combinational. Backpressure: en low forces an all-zero grant; gnt_idx still shows the winner.
// Reused by other shared-unit schedulers, so it holds no state of its own.
module rr_arbiter_onehot #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic found;

    // Two passes: indices above the pointer first, then wrap to the bottom.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (IDW'(i) > last_grant)) begin
                found   = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                found   = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = en && found && (gnt_idx == IDW'(i));
        end
    end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Shares one carry-lookahead adder among NREQ requesters with round-robin grant; optional ADDER_RR_SCHEDULER_STATS_EN grant counters.
// Latency: 1 cycle accept-to-rsp_valid, one result per cycle. Backpressure: rsp_ready low while full blocks every req_ready.
module adder_rr_scheduler
    import adder_rr_scheduler_pkg::*;
#(
    parameter int n    = DEF_N,
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = DEF_IDW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*n-1:0]      req_x,
    input  logic [NREQ*n-1:0]      req_y,
    input  logic [NREQ-1:0]        req_cin,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [n:0]             rsp_sum
`ifdef ADDER_RR_SCHEDULER_STATS_EN
    ,
    input  logic                   stat_clr,
    output logic [NREQ*STAT_W-1:0] stat_grants
`endif
);

    rsp_state_t      state;
    logic [IDW-1:0]  last_grant;
    logic [IDW-1:0]  gnt_idx;
    logic [NREQ-1:0] gnt;
    logic            can_accept;
    logic            accept;
    logic [n-1:0]    x_sel, y_sel, p, g, s;
    logic            c_sel;
    logic [n:0]      c;

    assign can_accept = (state == RSP_EMPTY) || rsp_ready;

    // Gating with rst_n keeps every req_ready low while reset is asserted.
    rr_arbiter_onehot #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .en         (can_accept && rst_n),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;
    assign rsp_valid = (state == RSP_FULL);

    always_comb begin
        x_sel = '0;
        y_sel = '0;
        c_sel = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                x_sel = req_x[i*n +: n];
                y_sel = req_y[i*n +: n];
                c_sel = req_cin[i];
            end
        end
    end

    always_comb begin
        p    = x_sel | y_sel;
        g    = x_sel & y_sel;
        c    = '0;
        c[0] = c_sel;
        for (int i = 0; i < n; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        s = x_sel ^ y_sel ^ c[n-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RSP_EMPTY;
            last_grant <= IDW'(NREQ - 1);
            rsp_id     <= '0;
            rsp_sum    <= '0;
        end else if (accept) begin
            state      <= RSP_FULL;
            last_grant <= gnt_idx;
            rsp_id     <= gnt_idx;
            rsp_sum    <= {c[n], s};
        end else if ((state == RSP_FULL) && rsp_ready) begin
            state      <= RSP_EMPTY;
        end
    end

`ifdef ADDER_RR_SCHEDULER_STATS_EN
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_stat
            logic [STAT_W-1:0] cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (stat_clr) begin
                    cnt <= '0;
                end else if (gnt[gi] && (cnt != STAT_SAT)) begin
                    cnt <= cnt + 1'b1;
                end
            end
            assign stat_grants[gi*STAT_W +: STAT_W] = cnt;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Self-checking bench for adder_rr_scheduler: scoreboard of expected {id,sum} pushed on accept, popped on output.
// Stats checks compile only with ADDER_RR_SCHEDULER_STATS_EN defined.
module tb_adder_rr_scheduler;
    localparam int N    = 64;
    localparam int NREQ = 4;

    typedef struct {
        logic [1:0]  id;
        logic [N:0]  sum;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_x, req_y;
    logic [NREQ-1:0]   req_cin;
    logic              rsp_valid, rsp_ready;
    logic [1:0]        rsp_id;
    logic [N:0]        rsp_sum;
`ifdef ADDER_RR_SCHEDULER_STATS_EN
    logic              stat_clr;
    logic [NREQ*16-1:0] stat_grants;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    adder_rr_scheduler #(.n(N), .NREQ(NREQ), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum)
`ifdef ADDER_RR_SCHEDULER_STATS_EN
        , .stat_clr(stat_clr), .stat_grants(stat_grants)
`endif
    );

    function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
    endfunction

    task automatic set_op(input int i, input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
        req_x[i*N +: N] = x;
        req_y[i*N +: N] = y;
        req_cin[i]      = c;
    endtask

    task automatic rand_op(input int i);
        set_op(i, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
    endtask

    // Record every handshake visible on the request side as an expected result.
    task automatic push_acc();
        exp_t e;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                e.id  = 2'(i);
                e.sum = model(req_x[i*N +: N], req_y[i*N +: N], req_cin[i]);
                q.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
`ifdef ADDER_RR_SCHEDULER_STATS_EN
        stat_clr  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        req_x = '0; req_y = '0; req_cin = '0;
`ifdef ADDER_RR_SCHEDULER_STATS_EN
        stat_clr  = 1'b0;
`endif
        #3;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
        checks++; if (rsp_sum !== '0) begin errors++; $display("FAIL reset_rsp_sum got=%h want=0", rsp_sum); end
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
    endtask

    task automatic test_single();
        exp_t e;
        rst_n     = 1'b1;
        req_valid = 4'b0001;
        set_op(0, 64'd5, 64'd7, 1'b1);
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b want=0001", req_ready); end
        push_acc();
        @(negedge clk);
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b want=1", rsp_valid); end
        checks++; if (rsp_sum !== 65'd13) begin errors++; $display("FAIL single_sum got=%0d want=13", rsp_sum); end
        if (q.size() == 0) begin errors++; checks++; $display("FAIL single_sb got=empty want=entry"); end
        else begin
            e = q.pop_front();
            checks++; if (rsp_id !== e.id) begin errors++; $display("FAIL single_id got=%0d want=%0d", rsp_id, e.id); end
        end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b want=0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        exp_t       e;
        logic [3:0] want;
        int         last_acc = -1;
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) rand_op(i);
        req_valid = 4'hF;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                @(negedge clk);
                checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_bubble k=%0d got=%b want=1", k, rsp_valid); end
                checks++; if (rsp_id !== 2'((k - 1) % 4)) begin errors++; $display("FAIL rr_order k=%0d got=%0d want=%0d", k, rsp_id, (k - 1) % 4); end
                if (q.size() == 0) begin errors++; checks++; $display("FAIL rr_sb got=empty want=entry"); end
                else begin
                    e = q.pop_front();
                    checks++; if (rsp_sum !== e.sum) begin errors++; $display("FAIL rr_sum k=%0d got=%h want=%h", k, rsp_sum, e.sum); end
                end
                if (last_acc >= 0) rand_op(last_acc);
            end
            if (k < 8) begin
                #1;
                want = 4'b0001 << (k % 4);
                checks++; if (req_ready !== want) begin errors++; $display("FAIL rr_ready k=%0d got=%b want=%b", k, req_ready, want); end
                push_acc();
                last_acc = k % 4;
            end
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_carry();
        int          idx [4] = '{2, 3, 1, 0};
        logic [63:0] xs  [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h8000_0000_0000_0000};
        logic [63:0] ys  [4] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h8000_0000_0000_0000};
        logic        cs  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [64:0] want[4] = '{65'h1_0000_0000_0000_0000, 65'h1_FFFF_FFFF_FFFF_FFFF, 65'h0, 65'h1_0000_0000_0000_0000};
        logic [3:0]  wr;
        do_reset();
        rsp_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            set_op(idx[t], xs[t], ys[t], cs[t]);
            req_valid = 4'b0001 << idx[t];
            wr        = 4'b0001 << idx[t];
            #1;
            checks++; if (req_ready !== wr) begin errors++; $display("FAIL carry_ready t=%0d got=%b want=%b", t, req_ready, wr); end
            @(negedge clk);
            req_valid = '0;
            checks++; if (rsp_sum !== want[t]) begin errors++; $display("FAIL carry_sum t=%0d got=%h want=%h", t, rsp_sum, want[t]); end
            checks++; if (rsp_id !== 2'(idx[t])) begin errors++; $display("FAIL carry_id t=%0d got=%0d want=%0d", t, rsp_id, idx[t]); end
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        exp_t e, hold;
        do_reset();
        rsp_ready = 1'b1;
        set_op(0, 64'h1234, 64'h4321, 1'b0);
        req_valid = 4'b0001;
        #1;
        push_acc();
        @(negedge clk);
        rsp_ready = 1'b0;
        set_op(1, 64'hAAAA_0000, 64'h0000_5555, 1'b1);
        set_op(3, 64'd100, 64'd200, 1'b0);
        req_valid = 4'b1010;
        hold.id = 2'd0;
        hold.sum = 65'h5555;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready c=%0d got=%b want=0000", c, req_ready); end
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== hold.id || rsp_sum !== hold.sum)
                begin errors++; $display("FAIL stall_hold c=%0d got=%b/%0d/%h want=1/%0d/%h", c, rsp_valid, rsp_id, rsp_sum, hold.id, hold.sum); end
        end
        rsp_ready = 1'b1;
        if (q.size() != 0) e = q.pop_front();
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL stall_release got=%b want=0010", req_ready); end
        push_acc();
        @(negedge clk);
        req_valid[1] = 1'b0;
        checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL stall_next_id got=%0d want=1", rsp_id); end
        if (q.size() == 0) begin errors++; checks++; $display("FAIL stall_sb got=empty want=entry"); end
        else begin
            e = q.pop_front();
            checks++; if (rsp_sum !== e.sum) begin errors++; $display("FAIL stall_next_sum got=%h want=%h", rsp_sum, e.sum); end
        end
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL stall_then3 got=%b want=1000", req_ready); end
        push_acc();
        @(negedge clk);
        req_valid = '0;
        checks++; if (rsp_id !== 2'd3 || rsp_sum !== 65'd300) begin errors++; $display("FAIL stall_r3 got=%0d/%0d want=3/300", rsp_id, rsp_sum); end
        q.delete();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got=%b want=0", rsp_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsp_ready = 1'b0;
        set_op(2, 64'd9, 64'd9, 1'b0);
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre got=%b want=1", rsp_valid); end
        #2;
        rst_n     = 1'b0;
        req_valid = 4'hF;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_async got=%b want=0", rsp_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ready got=%b want=0000", req_ready); end
        q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) rand_op(i);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_first got=%b want=0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL midrst_id got=%0d want=0", rsp_id); end
        @(negedge clk);
    endtask

    task automatic test_random();
        exp_t       e;
        logic [3:0] acc = '0;
        logic [3:0] want;
        int         age [NREQ];
        int         mlast = NREQ - 1;
        logic       mfull = 1'b0;
        int         gsel;
        do_reset();
        for (int i = 0; i < NREQ; i++) age[i] = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            rsp_ready = ($urandom_range(0, 3) != 0);
            checks++; if (rsp_valid !== mfull) begin errors++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", cyc, rsp_valid, mfull); end
            if (rsp_valid === 1'b1 && rsp_ready) begin
                if (q.size() == 0) begin errors++; checks++; $display("FAIL rand_sb cyc=%0d got=empty want=entry", cyc); end
                else begin
                    e = q.pop_front();
                    checks++; if (rsp_id !== e.id || rsp_sum !== e.sum)
                        begin errors++; $display("FAIL rand_rsp cyc=%0d got=%0d/%h want=%0d/%h", cyc, rsp_id, rsp_sum, e.id, e.sum); end
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    age[i] = 0;
                    req_valid[i] = 1'($urandom_range(0, 1));
                    if (req_valid[i]) rand_op(i);
                end
            end
            #1;
            gsel = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (gsel < 0 && req_valid[(mlast + k) % NREQ]) gsel = (mlast + k) % NREQ;
            end
            want = (gsel >= 0 && (!mfull || rsp_ready)) ? (4'b0001 << gsel) : 4'b0000;
            checks++; if (req_ready !== want) begin errors++; $display("FAIL rand_grant cyc=%0d got=%b want=%b", cyc, req_ready, want); end
            push_acc();
            acc = req_valid & req_ready;
            if (want != 0) begin
                mlast = gsel;
                mfull = 1'b1;
                for (int i = 0; i < NREQ; i++) begin
                    if (req_valid[i] && !acc[i]) begin
                        age[i]++;
                        checks++; if (age[i] >= NREQ) begin errors++; $display("FAIL rand_fair req=%0d got=%0d want<%0d", i, age[i], NREQ); end
                    end
                end
            end else if (rsp_ready) begin
                mfull = 1'b0;
            end
        end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        q.delete();
    endtask

`ifdef ADDER_RR_SCHEDULER_STATS_EN
    task automatic test_stats();
        do_reset();
        rsp_ready = 1'b1;
        set_op(3, 64'd1, 64'd2, 1'b0);
        req_valid = 4'b1000;
        repeat (10) @(negedge clk);
        checks++; if (stat_grants[63:48] !== 16'd10) begin errors++; $display("FAIL stats_count got=%0d want=10", stat_grants[63:48]); end
        checks++; if (stat_grants[15:0] !== 16'd0) begin errors++; $display("FAIL stats_other got=%0d want=0", stat_grants[15:0]); end
        repeat (69990) @(negedge clk);
        checks++; if (stat_grants[63:48] !== 16'hFFFF) begin errors++; $display("FAIL stats_sat got=%h want=ffff", stat_grants[63:48]); end
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr  = 1'b0;
        req_valid = '0;
        checks++; if (stat_grants[63:48] !== 16'd0) begin errors++; $display("FAIL stats_clr got=%h want=0", stat_grants[63:48]); end
        @(negedge clk);
        q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_carry();
        test_stall();
        test_reset_mid();
        test_random();
`ifdef ADDER_RR_SCHEDULER_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
